perf_counter_bank: RTL

PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

---
 rtl/perf_pkg.sv | 7 +
 rtl/perf_ctr.sv | 31 +++
 rtl/perf_counter_bank.sv | 101 ++++++++++
 3 files changed

// File: rtl/perf_pkg.sv
// perf_pkg: shared FSM state encoding and read-address width helper for the perf counter bank
package perf_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HALTED = 2'd2} state_e;
   function automatic int addr_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/perf_ctr.sv
// perf_ctr: one CNT_W event counter with clear, optional saturation and sticky overflow
module perf_ctr #(
   parameter int CNT_W    = 32,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt_o,
   output logic             ovf_o
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d, full;
   always_comb begin
      full  = &cnt_q;
      cnt_d = clr ? '0 : !inc ? cnt_q : (full && SATURATE) ? cnt_q : cnt_q + CNT_W'(1);
      ovf_d = !clr && (ovf_q || (inc && full));
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end
   assign cnt_o = cnt_q;
   assign ovf_o = ovf_q;
endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank: cycle counter plus NUM_CH event counters with IDLE/RUN/HALTED control and 1-cycle read port
// Define PERF_SNAPSHOT_EN to add a shadow bank captured on halt and on clear; reads then return the shadow bank.
module perf_counter_bank import perf_pkg::*; #(
   parameter int NUM_CH   = 4,
   parameter int CNT_W    = 32,
   parameter bit SATURATE = 1'b0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      clear,
   input  logic                      halt,
   input  logic [NUM_CH-1:0]         evt,
   input  logic                      rd_req,
   input  logic [addr_w(NUM_CH)-1:0] rd_addr,
   output logic                      rd_valid,
   output logic [CNT_W-1:0]          rd_data,
   output logic                      rd_err,
   output logic [NUM_CH:0]           ovf,
   output logic [1:0]                state_o
);
   localparam int AW = addr_w(NUM_CH);
   localparam int NA = 2 ** AW;
   state_e           state_q;
   logic [NUM_CH:0]  inc;
   logic [CNT_W-1:0] cnt [NA];
   logic [CNT_W-1:0] rd_pick, rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d, rd_err_q, rd_err_d;
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else state_q <= clear ? IDLE :
                      (state_q == IDLE && start) ? RUN :
                      (state_q == RUN && halt) ? HALTED : state_q;
   end
   // The halting cycle still counts; freezing starts once the state has left RUN.
   assign inc = {evt, 1'b1} & {(NUM_CH + 1){state_q == RUN && !clear}};
   for (genvar i = 0; i < NA; i++) begin : g_ctr
      if (i <= NUM_CH) begin : g_on
         perf_ctr #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_ctr (
            .clk  (clk),
            .rst  (rst),
            .inc  (inc[i]),
            .clr  (clear),
            .cnt_o(cnt[i]),
            .ovf_o(ovf[i])
         );
      end else begin : g_off
         assign cnt[i] = '0;
      end
   end
`ifdef PERF_SNAPSHOT_EN
   logic [CNT_W-1:0] snap_q [NA];
   logic [CNT_W-1:0] snap_d [NA];
   logic [NUM_CH:0]  snap_ovf_q, snap_ovf_d;
   logic             snap_pend_q, snap_pend_d;
   // Capture one cycle after the halting edge so the halting cycle's counts are included.
   always_comb begin
      snap_pend_d = state_q == RUN && halt && !clear;
      snap_d      = snap_q;
      snap_ovf_d  = snap_ovf_q;
      if (snap_pend_q || clear) begin
         snap_d     = cnt;
         snap_ovf_d = ovf;
      end
      rd_pick = snap_q[rd_addr];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         snap_q      <= '{default: '0};
         snap_ovf_q  <= '0;
         snap_pend_q <= 1'b0;
      end else begin
         snap_q      <= snap_d;
         snap_ovf_q  <= snap_ovf_d;
         snap_pend_q <= snap_pend_d;
      end
   end
`else
   assign rd_pick = cnt[rd_addr];
`endif
   always_comb begin
      rd_valid_d = rd_req;
      rd_err_d   = rd_req && rd_addr > AW'(NUM_CH);
      rd_data_d  = (!rd_req || rd_err_d) ? '0 : rd_pick;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_err_q   <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= rd_valid_d;
         rd_err_q   <= rd_err_d;
         rd_data_q  <= rd_data_d;
      end
   end
   assign rd_valid = rd_valid_q;
   assign rd_err   = rd_err_q;
   assign rd_data  = rd_data_q;
   assign state_o  = state_q;
endmodule
